// File: rtl/tinyalu_arbiter.sv
// Shares one TinyALU between N_REQ valid/ready requesters and returns id-tagged results.
// Build option: define TINYALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module tinyalu_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 255,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic [3*N_REQ-1:0]   req_op,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_error,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  state_t                  state;
  cmd_t                    alu_cmd;
  logic [IDW-1:0]          cur_id;
  logic [15:0]             cnt;
  logic [16:0]             cnt_nxt;
  logic                    grant_any;
  logic [IDW-1:0]          grant_id;
  logic [IDW-1:0]          sel;
  logic [2:0]              sel_op;
  logic                    go_alu;

  logic [N_REQ-1:0][7:0]   a_v;
  logic [N_REQ-1:0][7:0]   b_v;
  logic [N_REQ-1:0][2:0]   op_v;

  assign a_v  = req_a;
  assign b_v  = req_b;
  assign op_v = req_op;

`ifndef TINYALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]          last_grant;
`endif

  // Descending scan: the last hit written is the highest-priority candidate.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    sel       = '0;
`ifdef TINYALU_ARB_FIXED_PRIO_EN
    for (int i = N_REQ-1; i >= 0; i--) begin
      sel = IDW'(i);
      if (req_valid[sel]) begin
        grant_any = 1'b1;
        grant_id  = sel;
      end
    end
`else
    for (int i = N_REQ; i >= 1; i--) begin
      sel = (int'(last_grant) + i >= N_REQ) ? IDW'(int'(last_grant) + i - N_REQ)
                                             : IDW'(int'(last_grant) + i);
      if (req_valid[sel]) begin
        grant_any = 1'b1;
        grant_id  = sel;
      end
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && grant_any) req_ready[grant_id] = 1'b1;
  end

  assign sel_op  = op_v[grant_id];
  assign go_alu  = (sel_op != 3'd0) && (sel_op <= 3'd4);
  assign cnt_nxt = {1'b0, cnt} + 17'd1;

  assign alu_a   = alu_cmd.a;
  assign alu_b   = alu_cmd.b;
  assign alu_op  = alu_cmd.op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alu_cmd    <= '0;
      alu_start  <= 1'b0;
      cur_id     <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
`ifndef TINYALU_ARB_FIXED_PRIO_EN
      last_grant <= IDW'(N_REQ-1);
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            cur_id <= grant_id;
            cnt    <= '0;
`ifndef TINYALU_ARB_FIXED_PRIO_EN
            last_grant <= grant_id;
`endif
            if (go_alu) begin
              state     <= BUSY;
              alu_start <= 1'b1;
              alu_cmd   <= '{a: a_v[grant_id], b: b_v[grant_id], op: sel_op};
            end else begin
              // no_op and illegal opcodes answer immediately without touching the ALU
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_id     <= grant_id;
              rsp_result <= '0;
              rsp_error  <= (sel_op > 3'd4);
            end
          end
        end
        BUSY: begin
          cnt <= cnt_nxt[15:0];
          if (alu_done || cnt_nxt == 17'(TIMEOUT)) begin
            state      <= RESP;
            alu_start  <= 1'b0;
            alu_cmd    <= '0;
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= alu_done ? alu_result : 16'h0000;
            rsp_error  <= !alu_done;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a behavioural ALU whose done latency is programmable.
module tb_tinyalu_arbiter;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][7:0]  ra, rb;
  logic [3:0][2:0]  rop;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [15:0]      rsp_result;
  logic             rsp_error;
  logic [7:0]       alu_a, alu_b;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_done;
  logic [15:0]      alu_result;

  int checks = 0, errors = 0;
  int start_cyc = 0, rsp_cnt = 0, multi_rdy = 0;
  int done_dly = 0, scnt = 0;
  int s;

  tinyalu_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(ra), .req_b(rb), .req_op(rop),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // ALU model: done rises in the done_dly-th cycle of a start run; done_dly 0 means never.
  always @(posedge clk) begin
    if (alu_start) start_cyc++;
    if (rsp_valid) rsp_cnt++;
    if ($countones(req_ready) > 1) multi_rdy++;
    scnt <= alu_start ? scnt + 1 : 0;
  end

  assign alu_done = alu_start && (done_dly != 0) && (scnt == done_dly - 1);

  always_comb begin
    case (alu_op)
      3'd1:    alu_result = {8'h00, alu_a} + {8'h00, alu_b};
      3'd2:    alu_result = {8'h00, alu_a & alu_b};
      3'd3:    alu_result = {8'h00, alu_a ^ alu_b};
      3'd4:    alu_result = alu_a * alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  // Entered at an IDLE negedge with inputs driven; leaves at the following IDLE negedge.
  task automatic serve(input string tag, input logic [3:0] exp_rdy, input int lat,
                       input logic [1:0] exp_id, input logic [2:0] exp_op,
                       input logic [15:0] exp_res, input logic exp_err, input bit drop);
    #1 chk({tag, "_rdy"}, req_ready, exp_rdy);
    @(negedge clk);
    chk({tag, "_start"}, alu_start, (lat > 0));
    chk({tag, "_op"}, alu_op, (lat > 0) ? exp_op : 3'd0);
    if (drop) req_valid[exp_id] = 1'b0;
    wait_rsp(tag, lat);
    chk({tag, "_id"}, rsp_id, exp_id);
    chk({tag, "_res"}, rsp_result, exp_res);
    chk({tag, "_err"}, rsp_error, exp_err);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; ra = '0; rb = '0; rop = '0; done_dly = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_result", rsp_result, 16'h0000);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_alu_start", alu_start, 1'b0);
    chk("rst_alu_ab", {alu_a, alu_b, alu_op}, 19'd0);
    reset = 1'b0;
    @(negedge clk);

    // single add from requester 2
    ra[2] = 8'h12; rb[2] = 8'h34; rop[2] = 3'b001; req_valid = 4'b0100; done_dly = 1;
    s = start_cyc;
    serve("add", 4'b0100, 1, 2'd2, 3'b001, 16'h0046, 1'b0, 1'b1);
    chk("add_starts", start_cyc - s, 1);
    chk("add_hold", {rsp_valid, rsp_result}, {1'b0, 16'h0046});

    // round-robin contention after a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ra[k] = 8'hFF; rb[k] = 8'hFF; rop[k] = 3'b100;
    end
    req_valid = 4'hF; done_dly = 3;
    s = rsp_cnt;
    for (int k = 0; k < 4; k++)
      serve("rr", 4'(1 << k), 3, 2'(k), 3'b100, 16'hFE01, 1'b0, 1'b1);
    chk("rr_rsp_cnt", rsp_cnt - s, 4);

    // illegal opcode then no_op
    s = start_cyc;
    rop[1] = 3'b110; ra[1] = 8'h11; rb[1] = 8'h22; req_valid = 4'b0010;
    serve("ill", 4'b0010, 0, 2'd1, 3'b110, 16'h0000, 1'b1, 1'b1);
    rop[1] = 3'b000; req_valid = 4'b0010;
    serve("nop", 4'b0010, 0, 2'd1, 3'b000, 16'h0000, 1'b0, 1'b1);
    chk("spc_starts", start_cyc - s, 0);

    // timeout, then the next request is accepted
    done_dly = 0;
    ra[3] = 8'h01; rb[3] = 8'h02; rop[3] = 3'b001; req_valid = 4'b1000;
    s = start_cyc;
    serve("tmo", 4'b1000, TIMEOUT, 2'd3, 3'b001, 16'h0000, 1'b1, 1'b1);
    chk("tmo_starts", start_cyc - s, TIMEOUT);
    done_dly = 1;
    ra[0] = 8'h05; rb[0] = 8'h06; rop[0] = 3'b001; req_valid = 4'b0001;
    serve("post_tmo", 4'b0001, 1, 2'd0, 3'b001, 16'h000B, 1'b0, 1'b1);

    // reset while a mul is in BUSY
    done_dly = 0;
    ra[1] = 8'h03; rb[1] = 8'h04; rop[1] = 3'b100; req_valid = 4'b0010;
    #1 chk("mid_rdy", req_ready, 4'b0010);
    @(negedge clk);
    chk("mid_busy", alu_start, 1'b1);
    ra[0] = 8'h10; rb[0] = 8'h20; rop[0] = 3'b001;
    ra[2] = 8'hAA; rb[2] = 8'h0F; rop[2] = 3'b011;
    req_valid = 4'b0101;
    s = rsp_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_start_drop", alu_start, 1'b0);
    chk("mid_no_rsp", rsp_valid, 1'b0);
    chk("mid_op_clr", alu_op, 3'd0);
    chk("mid_rdy_in_rst", req_ready, 4'b0000);
    chk("mid_rsp_cnt", rsp_cnt - s, 0);
    reset = 1'b0; done_dly = 1;
    serve("mid_g0", 4'b0001, 1, 2'd0, 3'b001, 16'h0030, 1'b0, 1'b1);
    serve("mid_g2", 4'b0100, 1, 2'd2, 3'b011, 16'h00A5, 1'b0, 1'b1);

    // requesters 0 and 3 held continuously valid
    ra[0] = 8'h01; rb[0] = 8'h01; rop[0] = 3'b001;
    ra[3] = 8'hF0; rb[3] = 8'h3C; rop[3] = 3'b010;
    req_valid = 4'b1001;
    for (int r = 0; r < 3; r++) begin
`ifdef TINYALU_ARB_FIXED_PRIO_EN
      serve("prio", 4'b0001, 1, 2'd0, 3'b001, 16'h0002, 1'b0, 1'b0);
`else
      if (r % 2 == 0) serve("prio", 4'b1000, 1, 2'd3, 3'b010, 16'h0030, 1'b0, 1'b0);
      else            serve("prio", 4'b0001, 1, 2'd0, 3'b001, 16'h0002, 1'b0, 1'b0);
`endif
    end
    req_valid = '0;
    @(negedge clk);
    chk("one_ready", multi_rdy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
